// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared bus widths, ALU op indices and ID->EXE bus layout
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 150;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_TO_DS_FWD_WD = 39;

  localparam int ALU_OP_ADD  = 0;
  localparam int ALU_OP_SUB  = 1;
  localparam int ALU_OP_SLT  = 2;
  localparam int ALU_OP_SLTU = 3;
  localparam int ALU_OP_AND  = 4;
  localparam int ALU_OP_NOR  = 5;
  localparam int ALU_OP_OR   = 6;
  localparam int ALU_OP_XOR  = 7;
  localparam int ALU_OP_SLL  = 8;
  localparam int ALU_OP_SRL  = 9;
  localparam int ALU_OP_SRA  = 10;
  localparam int ALU_OP_LUI  = 11;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        res_from_mem;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_to_es_t;

endpackage

// File: rtl/exe_stage_alu.sv
// rtl/exe_stage_alu.sv - combinational 32-bit ALU with one adder shared by add/sub/slt/sltu
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic        use_sub;
  logic [31:0] adder_b;
  logic [32:0] adder_out;
  logic        slt_res;
  logic        sltu_res;

  // sub/slt/sltu all compute src1 + ~src2 + 1 on the same adder
  assign use_sub   = alu_op[ALU_OP_SUB] | alu_op[ALU_OP_SLT] | alu_op[ALU_OP_SLTU];
  assign adder_b   = use_sub ? ~alu_src2 : alu_src2;
  assign adder_out = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};

  assign slt_res  = (alu_src1[31] & ~alu_src2[31])
                  | (~(alu_src1[31] ^ alu_src2[31]) & adder_out[31]);
  assign sltu_res = ~adder_out[32];

  always_comb begin
    alu_result = 32'd0;
    alu_result = alu_result | ({32{alu_op[ALU_OP_ADD] | alu_op[ALU_OP_SUB]}} & adder_out[31:0]);
    alu_result = alu_result | ({32{alu_op[ALU_OP_SLT]}}  & {31'd0, slt_res});
    alu_result = alu_result | ({32{alu_op[ALU_OP_SLTU]}} & {31'd0, sltu_res});
    alu_result = alu_result | ({32{alu_op[ALU_OP_AND]}}  & (alu_src1 & alu_src2));
    alu_result = alu_result | ({32{alu_op[ALU_OP_NOR]}}  & ~(alu_src1 | alu_src2));
    alu_result = alu_result | ({32{alu_op[ALU_OP_OR]}}   & (alu_src1 | alu_src2));
    alu_result = alu_result | ({32{alu_op[ALU_OP_XOR]}}  & (alu_src1 ^ alu_src2));
    alu_result = alu_result | ({32{alu_op[ALU_OP_SLL]}}  & (alu_src1 << alu_src2[4:0]));
    alu_result = alu_result | ({32{alu_op[ALU_OP_SRL]}}  & (alu_src1 >> alu_src2[4:0]));
    alu_result = alu_result | ({32{alu_op[ALU_OP_SRA]}}
                              & 32'($signed(alu_src1) >>> alu_src2[4:0]));
    alu_result = alu_result | ({32{alu_op[ALU_OP_LUI]}}  & alu_src2);
  end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - EXE pipeline stage: ID bus latch, operand select, ALU, data SRAM request
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_FWD_WD-1:0] es_to_ds_fwd,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic        es_valid;
  logic        es_ready_go;
  ds_to_es_t   es_r;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid <= 1'b0;
      es_r     <= '0;
    end else begin
      if (es_allowin) begin
        es_valid <= ds_to_es_valid;
      end
      if (ds_to_es_valid && es_allowin) begin
        es_r <= ds_to_es_bus;
      end
    end
  end

  assign alu_src1 = es_r.src1_is_pc  ? es_r.pc  : es_r.rj_value;
  assign alu_src2 = es_r.src2_is_imm ? es_r.imm : es_r.rkd_value;

  exe_stage_alu u_alu (
    .alu_op     (es_r.alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result)
  );

  // A stalled store keeps its request up but only writes on the handoff cycle
  assign data_sram_en    = es_valid && (es_r.res_from_mem || es_r.mem_we);
  assign data_sram_we    = {4{es_valid && es_r.mem_we && ms_allowin}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_r.rkd_value;

  assign es_to_ms_bus = {es_r.res_from_mem, es_r.gr_we, es_r.dest, alu_result, es_r.pc};
  assign es_to_ds_fwd = {es_valid && es_r.gr_we, es_valid && es_r.res_from_mem,
                         es_r.dest, alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage with output scoreboard
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [149:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_fwd;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_pass  = 0;
  int n_total = 0;
  int wr_count = 0;
  logic [70:0] exp_q[$];
  ds_to_es_t   d;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_fwd    (es_to_ds_fwd),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [11:0] op(input int i);
    logic [11:0] one;
    one = 12'd1;
    return one << i;
  endfunction

  task automatic issue(input logic [11:0] aop, input logic rfm, input logic s1pc,
                       input logic s2imm, input logic gwe, input logic mwe,
                       input logic [4:0] dest, input logic [31:0] imm, input logic [31:0] rj,
                       input logic [31:0] rk, input logic [31:0] pc, input logic [31:0] exp_res);
    d = '{aop, rfm, s1pc, s2imm, gwe, mwe, dest, imm, rj, rk, pc};
    ds_to_es_bus   = d;
    ds_to_es_valid = 1'b1;
    exp_q.push_back({rfm, gwe, dest, exp_res, pc});
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Every instruction leaving EXE is matched against the oldest expectation
  always @(negedge clk) begin
    if (data_sram_we != 4'h0) wr_count++;
    if (resetn && es_to_ms_valid && ms_allowin) begin
      if (exp_q.size() == 0) chk("unexpected_out", es_to_ms_bus, 71'd0);
      else chk("ms_bus", es_to_ms_bus, exp_q.pop_front());
    end
  end

  initial begin
    resetn = 1'b0; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    @(negedge clk);
    chk("rst_valid", 71'(es_to_ms_valid), 71'd0);
    chk("rst_en_we", 71'({data_sram_en, data_sram_we}), 71'd0);
    chk("rst_fwd_bits", 71'(es_to_ds_fwd[38:37]), 71'd0);
    chk("rst_allowin", 71'(es_allowin), 71'd1);
    idle(); resetn = 1'b1;
    idle();

    // add.w overflow wraps; result must be on the bus exactly one cycle later
    issue(op(ALU_OP_ADD), 0, 0, 0, 1, 0, 5'd5, 32'd0, 32'h7fffffff, 32'd1, 32'h1c000000, 32'h80000000);
    @(negedge clk);
    chk("add_latency_valid", 71'(es_to_ms_valid), 71'd1);
    chk("add_fwd", 71'({es_to_ds_fwd[38:37], es_to_ds_fwd[36:0]}), 71'({2'b10, 5'd5, 32'h80000000}));
    issue(op(ALU_OP_SUB),  0, 0, 0, 1, 0, 5'd6, 32'd0, 32'd5, 32'd7, 32'h1c000004, 32'hfffffffe);
    issue(op(ALU_OP_SLT),  0, 0, 0, 1, 0, 5'd7, 32'd0, 32'hffffffff, 32'd1, 32'h1c000008, 32'd1);
    issue(op(ALU_OP_SLTU), 0, 0, 0, 1, 0, 5'd8, 32'd0, 32'hffffffff, 32'd1, 32'h1c00000c, 32'd0);
    issue(op(ALU_OP_AND),  0, 0, 0, 1, 0, 5'd9, 32'd0, 32'hf0f0f0f0, 32'hff00ff00, 32'h1c000010, 32'hf000f000);
    issue(op(ALU_OP_NOR),  0, 0, 0, 1, 0, 5'd10, 32'd0, 32'hf0f0f0f0, 32'hff00ff00, 32'h1c000014, 32'h000f000f);
    issue(op(ALU_OP_OR),   0, 0, 0, 1, 0, 5'd11, 32'd0, 32'hf0f0f0f0, 32'hff00ff00, 32'h1c000018, 32'hfff0fff0);
    issue(op(ALU_OP_XOR),  0, 0, 0, 1, 0, 5'd12, 32'd0, 32'hf0f0f0f0, 32'hff00ff00, 32'h1c00001c, 32'h0ff00ff0);
    issue(op(ALU_OP_SLL),  0, 0, 0, 1, 0, 5'd13, 32'd0, 32'd1, 32'd33, 32'h1c000020, 32'd2);
    issue(op(ALU_OP_SRL),  0, 0, 1, 1, 0, 5'd14, 32'd31, 32'h80000000, 32'd0, 32'h1c000024, 32'd1);
    issue(op(ALU_OP_SRA),  0, 0, 1, 1, 0, 5'd15, 32'd31, 32'h80000000, 32'd0, 32'h1c000028, 32'hffffffff);
    issue(op(ALU_OP_LUI),  0, 0, 1, 1, 0, 5'd16, 32'h12345000, 32'hdeadbeef, 32'd0, 32'h1c00002c, 32'h12345000);
    issue(12'd0,           0, 0, 0, 1, 0, 5'd17, 32'd0, 32'h11111111, 32'h22222222, 32'h1c000030, 32'd0);
    issue(op(ALU_OP_ADD),  0, 1, 1, 1, 0, 5'd1, 32'd4, 32'hbad0bad0, 32'd0, 32'h1c000100, 32'h1c000104);
    idle();
    chk("drained", 71'(exp_q.size()), 71'd0);

    // st.w stalled for 3 cycles must write exactly once, on handoff
    ms_allowin = 1'b0;
    issue(op(ALU_OP_ADD), 0, 0, 1, 0, 1, 5'd0, 32'hfffffffc, 32'h1000, 32'hdeadbeef, 32'h1c000200, 32'h00000ffc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_stall_en_we", 71'({data_sram_en, data_sram_we}), 71'({1'b1, 4'h0}));
      chk("st_stall_addr_wdata", 71'({data_sram_addr, data_sram_wdata}), 71'({32'h00000ffc, 32'hdeadbeef}));
      chk("st_stall_allowin", 71'({es_allowin, es_to_ms_valid}), 71'b01);
      idle();
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    chk("st_handoff_we", 71'(data_sram_we), 71'(4'hf));
    idle();
    @(negedge clk);
    chk("st_after_en_we", 71'({data_sram_en, data_sram_we}), 71'd0);
    chk("st_write_count", 71'(wr_count), 71'd1);

    // ld.w with bubbles: enable, load fwd bit and valid follow the occupied cycles
    issue(op(ALU_OP_ADD), 1, 0, 1, 1, 0, 5'd20, 32'd0, 32'h2000, 32'd0, 32'h1c000300, 32'h2000);
    @(negedge clk);
    chk("ld0", 71'({data_sram_en, es_to_ds_fwd[37], es_to_ms_valid}), 71'b111);
    idle();
    @(negedge clk);
    chk("ld_bubble0", 71'({data_sram_en, es_to_ds_fwd[37], es_to_ms_valid}), 71'b000);
    issue(op(ALU_OP_ADD), 1, 0, 1, 1, 0, 5'd21, 32'd4, 32'h2000, 32'd0, 32'h1c000304, 32'h2004);
    @(negedge clk);
    chk("ld1", 71'({data_sram_en, es_to_ds_fwd[37], es_to_ms_valid, data_sram_addr}), 71'({3'b111, 32'h2004}));
    issue(op(ALU_OP_ADD), 1, 0, 1, 1, 0, 5'd22, 32'd8, 32'h2000, 32'd0, 32'h1c000308, 32'h2008);
    @(negedge clk);
    chk("ld2", 71'({data_sram_en, es_to_ds_fwd[37], es_to_ms_valid, data_sram_we}), 71'({3'b111, 4'h0}));
    idle();
    @(negedge clk);
    chk("ld_bubble1", 71'({data_sram_en, es_to_ds_fwd[37], es_to_ms_valid}), 71'b000);

    // asynchronous reset while a st.w is stalled
    ms_allowin = 1'b0;
    issue(op(ALU_OP_ADD), 0, 0, 1, 0, 1, 5'd0, 32'h10, 32'h3000, 32'hcafef00d, 32'h1c000400, 32'h3010);
    @(negedge clk);
    chk("rst_pre_en_we", 71'({data_sram_en, data_sram_we, es_to_ms_valid}), 71'({1'b1, 4'h0, 1'b1}));
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_drop", 71'({es_to_ms_valid, data_sram_we, data_sram_en}), 71'd0);
    void'(exp_q.pop_back());
    idle(); resetn = 1'b1; ms_allowin = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_no_replay", 71'({es_to_ms_valid, data_sram_en}), 71'd0);
    chk("final_write_count", 71'(wr_count), 71'd1);
    chk("final_queue_empty", 71'(exp_q.size()), 71'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
